// File: rtl/reg_permute_pkg.sv
// Shared types for the register-permutation engine: FSM state encodings and mode constants.
// State encodings are visible on the phase debug port, so their values are fixed.
package reg_permute_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_MOVE    = 2'd2,
    ST_RESTORE = 2'd3
  } state_e;

  localparam logic MODE_SWAP   = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

endpackage

// File: rtl/reg_permute_bank.sv
// NREG x WIDTH register array plus temp register; one indexed write port, one temp load port.
// Two combinational read ports (external and move-source); writes land on the next clk edge.
module reg_permute_bank #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             t_load,
  input  logic [WIDTH-1:0] t_data,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic [IDXW-1:0]  src_idx,
  output logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] t_out
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] t_d;

  // Indices with no matching register never write, which drops out-of-range loads.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en && (wr_idx == IDXW'(i))) begin
        regs_d[i] = wr_data;
      end
    end
    t_d = t_load ? t_data : t_q;
  end

  always_comb begin
    rd_data  = '0;
    src_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_idx == IDXW'(i)) begin
        rd_data = regs_q[i];
      end
      if (src_idx == IDXW'(i)) begin
        src_data = regs_q[i];
      end
    end
  end

  assign t_out = t_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      t_q <= '0;
    end else begin
      regs_q <= regs_d;
      t_q    <= t_d;
    end
  end

endmodule

// File: rtl/reg_permute_unit.sv
// Register-permutation engine: swap two registers (3 busy cycles) or rotate the bank left (NREG+1).
// start/load honoured only in IDLE; requests while busy are ignored, done/err are 1-cycle pulses.
module reg_permute_unit
  import reg_permute_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [IDXW-1:0]  idx_a,
  input  logic [IDXW-1:0]  idx_b,
  input  logic             load,
  input  logic [IDXW-1:0]  load_idx,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       phase
);

  localparam logic [IDXW:0]   NREG_W    = (IDXW+1)'(NREG);
  localparam logic [IDXW-1:0] LAST_STEP = IDXW'(NREG - 2);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREG - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [IDXW-1:0]  idx_a_q, idx_a_d;
  logic [IDXW-1:0]  idx_b_q, idx_b_d;
  logic [IDXW-1:0]  step_q, step_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             t_load;
  logic [IDXW-1:0]  src_idx;
  logic [WIDTH-1:0] src_data;
  logic [WIDTH-1:0] t_out;
  logic             req_ok;

  // One extra bit on the compare so a power-of-two NREG still rejects nothing spuriously.
  assign req_ok = (mode == MODE_ROTATE) ||
                  (({1'b0, idx_a} < NREG_W) && ({1'b0, idx_b} < NREG_W));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    step_d  = step_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    t_load  = 1'b0;
    src_idx = '0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          wr_en   = 1'b1;
          wr_idx  = load_idx;
          wr_data = load_data;
        end else if (start) begin
          if (req_ok) begin
            state_d = ST_SAVE;
            mode_d  = mode;
            idx_a_d = idx_a;
            idx_b_d = idx_b;
            step_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SAVE: begin
        src_idx = (mode_q == MODE_ROTATE) ? '0 : idx_a_q;
        t_load  = 1'b1;
        state_d = ST_MOVE;
      end

      ST_MOVE: begin
        wr_en   = 1'b1;
        wr_data = src_data;
        if (mode_q == MODE_ROTATE) begin
          wr_idx  = step_q;
          src_idx = step_q + IDXW'(1);
          if (step_q == LAST_STEP) begin
            state_d = ST_RESTORE;
          end else begin
            step_d = step_q + IDXW'(1);
          end
        end else begin
          wr_idx  = idx_a_q;
          src_idx = idx_b_q;
          state_d = ST_RESTORE;
        end
      end

      ST_RESTORE: begin
        wr_en   = 1'b1;
        wr_idx  = (mode_q == MODE_ROTATE) ? LAST_IDX : idx_b_q;
        wr_data = t_out;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SWAP;
      idx_a_q <= '0;
      idx_b_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  reg_permute_bank #(
    .WIDTH(WIDTH),
    .NREG (NREG),
    .IDXW (IDXW)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .t_load  (t_load),
    .t_data  (src_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .src_idx (src_idx),
    .src_data(src_data),
    .t_out   (t_out)
  );

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign phase = state_q;

endmodule

// File: tb/tb_reg_permute_unit.sv
// Scoreboard bench for reg_permute_unit: NREG=4 instance for swap/rotate/reset cases,
// NREG=3 instance for out-of-range swap rejection and read/load boundaries.
module tb_reg_permute_unit;

  typedef struct {
    bit               is_done;
    int               busy_n;
    logic [3:0][7:0]  r;
    string            tag;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       start, mode, load;
  logic [1:0] idx_a, idx_b, load_idx, rd_idx;
  logic [7:0] load_data, rd_data;
  logic       busy, done, err;
  logic [1:0] phase;

  logic       start3, mode3, load3;
  logic [1:0] idx_a3, idx_b3, load_idx3, rd_idx3;
  logic [7:0] load_data3, rd_data3;
  logic       busy3, done3, err3;
  logic [1:0] phase3;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  int snap_req = 0, snap_seen = 0, busy_run = 0;
  int done_seen = 0, done_pushed = 0, err4_seen = 0, err3_seen = 0, done3_seen = 0;

  reg_permute_unit #(.WIDTH(8), .NREG(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .idx_a(idx_a), .idx_b(idx_b), .load(load), .load_idx(load_idx),
    .load_data(load_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .phase(phase)
  );

  reg_permute_unit #(.WIDTH(8), .NREG(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .mode(mode3),
    .idx_a(idx_a3), .idx_b(idx_b3), .load(load3), .load_idx(load_idx3),
    .load_data(load_data3), .rd_idx(rd_idx3), .rd_data(rd_data3),
    .busy(busy3), .done(done3), .err(err3), .phase(phase3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0][7:0] mk(input logic [7:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  // Monitor: owns rd_idx; reads the bank back over the read port within half a cycle.
  task automatic read_cmp(input logic [3:0][7:0] r, input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'h0, rd_data}, {24'h0, r[i]});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_seen++;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk({e.tag, "_kind"}, {31'h0, e.is_done}, 32'h1);
        chk({e.tag, "_busy_cycles"}, busy_run, e.busy_n);
        read_cmp(e.r, e.tag);
      end
    end else if (snap_seen != snap_req) begin
      snap_seen++;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk({e.tag, "_kind"}, {31'h0, e.is_done}, 32'h0);
        read_cmp(e.r, e.tag);
      end
    end
    if (err) err4_seen++;
    if (busy) busy_run++;
    else busy_run = 0;
  end

  always @(negedge clk) begin
    if (err3) err3_seen++;
    if (done3) done3_seen++;
  end

  task automatic snap(input logic [3:0][7:0] r, input string tag);
    exp_t e;
    e.is_done = 1'b0; e.busy_n = 0; e.r = r; e.tag = tag;
    sbq.push_back(e);
    snap_req++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [3:0][7:0] v);
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_idx = 2'(i); load_data = v[i];
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=busy required=idle", tag);
    end
  endtask

  task automatic run_op(input logic m, input logic [1:0] a, input logic [1:0] b,
                        input logic [3:0][7:0] r, input string tag);
    exp_t e;
    e.is_done = 1'b1; e.busy_n = m ? 5 : 3; e.r = r; e.tag = tag;
    sbq.push_back(e);
    done_pushed++;
    start = 1'b1; mode = m; idx_a = a; idx_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_accept"}, {31'h0, busy}, 32'h1);
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 0; mode = 0; load = 0; idx_a = 0; idx_b = 0; load_idx = 0; load_data = 0;
    start3 = 0; mode3 = 0; load3 = 0; idx_a3 = 0; idx_b3 = 0; load_idx3 = 0;
    load_data3 = 0; rd_idx3 = 0;
    rd_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_phase", {30'h0, phase}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    reset_n = 1'b1;
    snap(mk(8'h00, 8'h00, 8'h00, 8'h00), "rst_regs");

    load_all(mk(8'h11, 8'h22, 8'h33, 8'h44));
    snap(mk(8'h11, 8'h22, 8'h33, 8'h44), "loaded");
    run_op(1'b0, 2'd0, 2'd3, mk(8'h44, 8'h22, 8'h33, 8'h11), "swap03");

    load_all(mk(8'h11, 8'h22, 8'h33, 8'h44));
    run_op(1'b1, 2'd0, 2'd0, mk(8'h22, 8'h33, 8'h44, 8'h11), "rot1");
    run_op(1'b1, 2'd0, 2'd0, mk(8'h33, 8'h44, 8'h11, 8'h22), "rot2");
    run_op(1'b1, 2'd0, 2'd0, mk(8'h44, 8'h11, 8'h22, 8'h33), "rot3");
    run_op(1'b1, 2'd0, 2'd0, mk(8'h11, 8'h22, 8'h33, 8'h44), "rot4");
    run_op(1'b1, 2'd0, 2'd0, mk(8'h22, 8'h33, 8'h44, 8'h11), "rot5");

    run_op(1'b0, 2'd2, 2'd2, mk(8'h22, 8'h33, 8'h44, 8'h11), "swap22");

    // Load and start together: load wins, no operation starts.
    load = 1'b1; load_idx = 2'd1; load_data = 8'h5A;
    start = 1'b1; mode = 1'b0; idx_a = 2'd0; idx_b = 2'd3;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    chk("ldst_busy0", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("ldst_busy1", {31'h0, busy}, 32'h0);
    snap(mk(8'h22, 8'h5A, 8'h44, 8'h11), "ldst_regs");

    // Swap 1,2 while every input is churned during the busy window.
    begin
      exp_t e;
      e.is_done = 1'b1; e.busy_n = 3; e.r = mk(8'h22, 8'h44, 8'h5A, 8'h11); e.tag = "churn";
      sbq.push_back(e);
      done_pushed++;
    end
    start = 1'b1; mode = 1'b0; idx_a = 2'd1; idx_b = 2'd2;
    @(posedge clk); #1;
    chk("churn_accept", {31'h0, busy}, 32'h1);
    for (int c = 0; c < 8; c++) begin
      if (!busy) break;
      start = ((c & 1) == 0); load = 1'b1; load_idx = 2'(c);
      load_data = 8'hE0 + 8'(c); idx_a = 2'(3 - c); idx_b = 2'(c + 1); mode = ((c & 2) != 0);
      @(posedge clk); #1;
    end
    start = 1'b0; load = 1'b0; mode = 1'b0;
    snap(mk(8'h22, 8'h44, 8'h5A, 8'h11), "churn_after");

    // Reset in the middle of a rotate.
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrot_phase", {30'h0, phase}, 32'h2);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_phase", {30'h0, phase}, 32'h0);
    snap(mk(8'h00, 8'h00, 8'h00, 8'h00), "midrst_regs");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_done", {31'h0, done}, 32'h0);
    load_all(mk(8'h11, 8'h22, 8'h33, 8'h44));
    run_op(1'b0, 2'd0, 2'd1, mk(8'h22, 8'h11, 8'h33, 8'h44), "postrst_swap");

    // NREG=3 instance: out-of-range swap operand and out-of-range read/load.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      load3 = 1'b1; load_idx3 = 2'(i); load_data3 = 8'hA0 + 8'(16 * i);
      @(posedge clk); #1;
    end
    load3 = 1'b0;
    start3 = 1'b1; mode3 = 1'b0; idx_a3 = 2'd3; idx_b3 = 2'd0;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("n3_busy_rej", {31'h0, busy3}, 32'h0);
    chk("n3_err_pulse", {31'h0, err3}, 32'h1);
    @(posedge clk); #1;
    chk("n3_err_drop", {31'h0, err3}, 32'h0);
    chk("n3_busy_after", {31'h0, busy3}, 32'h0);
    load3 = 1'b1; load_idx3 = 2'd3; load_data3 = 8'hFF;
    @(posedge clk); #1;
    load3 = 1'b0;
    rd_idx3 = 2'd0; #1; chk("n3_r0", {24'h0, rd_data3}, 32'hA0);
    rd_idx3 = 2'd1; #1; chk("n3_r1", {24'h0, rd_data3}, 32'hB0);
    rd_idx3 = 2'd2; #1; chk("n3_r2", {24'h0, rd_data3}, 32'hC0);
    rd_idx3 = 2'd3; #1; chk("n3_r3_oob", {24'h0, rd_data3}, 32'h00);

    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_seen, done_pushed);
    chk("sb_empty", sbq.size(), 0);
    chk("snap_count", snap_seen, snap_req);
    chk("err4_count", err4_seen, 0);
    chk("err3_count", err3_seen, 1);
    chk("done3_count", done3_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_permute_unit.md
# reg_permute_unit

- Parametrised register-permutation engine: a bank of NREG registers, each WIDTH bits wide, plus one temp register, sequenced by an internal FSM.
- Two operations:
  - Swap any two registers (save / move / restore through the temp).
  - Rotate the whole bank left by one position.
- Sits beside the datapath register bank. Exposes a start/busy/done handshake, a direct load port and a read port.

## Interface
Parameters:
- WIDTH, 8, bits per register (>=1)
- NREG, 4, number of registers (>=2)
- IDXW, $clog2(NREG), index width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  request an operation; sampled only in IDLE
- mode  in  1  0 = swap idx_a/idx_b, 1 = rotate left by one
- idx_a, idx_b  in  IDXW  swap operands (ignored in rotate mode)
- load  in  1  write load_data into R[load_idx]; honoured only in IDLE
- load_idx  in  IDXW  load target
- load_data  in  WIDTH  load value
- rd_idx  in  IDXW  read index
- rd_data  out  WIDTH  combinational R[rd_idx]; 0 if rd_idx >= NREG
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  one-cycle pulse when a swap request has an index >= NREG
- phase  out  2  current state encoding, for debug/observability

## Operation
- States and encodings: IDLE=0, SAVE=1, MOVE=2, RESTORE=3.
- IDLE:
  - start=1, load=0, request valid: go to SAVE; latch mode, idx_a and idx_b internally.
  - load=1: R[load_idx] <= load_data; start is ignored that cycle. A load_idx >= NREG is dropped silently.
  - Swap with idx_a or idx_b >= NREG: stay in IDLE and pulse err next cycle; no register changes.
- Swap sequence:
  - SAVE: T <= R[a].
  - MOVE (1 cycle): R[a] <= R[b].
  - RESTORE: R[b] <= T, then go to IDLE.
- Rotate sequence:
  - SAVE: T <= R[0].
  - MOVE for k = 0..NREG-2, one per cycle, using step counter k (IDXW bits, cleared on SAVE entry): R[k] <= R[k+1]; leave MOVE when k == NREG-2.
  - RESTORE: R[NREG-1] <= T.
- Swap with a == b: the full 3-cycle sequence runs and contents are unchanged; done still pulses.
- start, load and input changes while busy are ignored; operands come from the latched copies.
- Reset, including mid-operation: state=IDLE, all R=0, T=0, step counter=0, busy=0, done=0, err=0, phase=0. A partially completed permutation is discarded.

## Timing
- start is accepted at edge E0. busy is high from E0 until the edge that leaves RESTORE.
- Swap: busy for exactly 3 cycles. Rotate: busy for exactly NREG+1 cycles.
- done and err are registered and high for exactly one cycle. done is high in the first IDLE cycle after RESTORE. err is high in the cycle after the rejected start.
- A new start may be accepted in the same cycle done is high; back-to-back operations leave no gap.
- rd_data has zero latency and reflects register writes from the previous edge. During an operation it shows intermediate contents.
- Width rules: comparisons against NREG use IDXW+1 bits so that NREG can be a power of two. The step counter never exceeds NREG-2.

## Structure
- Shared package reg_permute_pkg:
  - state enum with fixed encodings;
  - MODE_SWAP=0 and MODE_ROTATE=1 constants.
- Sub-module reg_permute_bank: NREG×WIDTH register array plus T.
  - One write port (index, data, enable) and one temp-load port.
  - Combinational read port, plus a second internal read for the move source.
- Top level contains the FSM, step counter, operand latches, load/start arbitration and the done/err registers.

## Test plan
- NREG=4, WIDTH=8. Load R={0x11,0x22,0x33,0x44}; swap a=0, b=3. Required: busy for 3 cycles, done pulses once, R={0x44,0x22,0x33,0x11}.
- Same initial load; rotate. Required: busy for 5 cycles, R={0x22,0x33,0x44,0x11}. Four back-to-back rotates restore the original contents.
- Swap a=2, b=2. Required: 3 busy cycles, done=1, contents unchanged. Then start with load=1 in the same cycle: load written, no operation, busy stays 0.
- NREG=3 with swap a=3. Required: err pulses 1 cycle, busy stays 0, contents unchanged, rd_idx=3 returns 0.
- Assert reset_n=0 in MOVE of a rotate. Required: immediately all registers 0, busy=0, phase=0; after release, a start is accepted normally.
- Change start, load, idx_a and idx_b every cycle while busy. Required: the result matches the latched request, and the load is not applied.
